midi_tx_scheduler: RTL and testbench
====================================

// Module: midi_tx_scheduler
// PURPOSE
//  Shares the single 31250-baud MIDI UART transmitter between two byte requesters (A: Miracle joypad
//  write path, B: host/HPS MIDI passthrough). Arbitrates at MIDI message boundaries so messages never
//  interleave, issues one byte at a time to the UART, and paces issues to one byte-time per byte.
// PARAMETERS
//  BYTE_CYCLES    6880      clk cycles between UART issues (10 bits x 688 @ 21.477 MHz)
//  LOCK_TIMEOUT   1048575   idle clks mid-message before lock is forcibly released
//  SENSE_CYCLES   6443100   idle clks before active-sense insert (300 ms; macro only)
// PORTS
//  clk            in   1   system clock, 21.477 MHz
//  reset_n        in   1   asynchronous active-low reset
//  a_data         in   8   requester A byte;  a_valid in 1;  a_ready out 1
//  b_data         in   8   requester B byte;  b_valid in 1;  b_ready out 1
//  uart_tdata_o   out  1   one-cycle load strobe to UART (tdata_i)
//  uart_data_o    out  16  UART frame {8'h01, byte}, held stable from issue until next issue
//  uart_txint_i   in   1   UART one-cycle start-of-shift pulse (acknowledge)
//  grant_o        out  2   one-hot current owner {B,A}; 2'b00 = no lock
//  busy_o         out  1   high in any state other than IDLE
//  timeout_o      out  1   one-cycle pulse when LOCK_TIMEOUT forces release
// BEHAVIOUR
//  Reset: all outputs 0 (uart_data_o=16'h0000), state IDLE, no lock, last_grant=B, remain=0.
//  Handshake: x_ready combinational = (state==IDLE) && owner==x; byte taken on x_valid&&x_ready.
//  Arbitration (IDLE, no lock): only A valid -> A; only B -> B; both -> not last_grant (round robin).
//   Grant and accept occur in the same cycle; last_grant updated on every new lock.
//  States: IDLE -> ISSUE (byte accepted) -> WAIT_ACK -> PACE -> IDLE.
//   ISSUE: 1 cycle; uart_tdata_o=1, uart_data_o={8'h01,byte}.
//   WAIT_ACK: wait for uart_txint_i=1 (unbounded); pulse in ISSUE cycle itself is ignored.
//   PACE: 16-bit counter loads BYTE_CYCLES-1 on ack, IDLE when it reaches 0 -> ack-to-next-ready
//   = BYTE_CYCLES cycles. No byte accepted outside IDLE.
//  Message length (on accepting a byte with no lock or remain==0 at start of message):
//   8x/9x/Ax/Bx/Ex/F2 -> 3; Cx/Dx/F1/F3 -> 2; F6, F4/F5, F7, F8-FF -> 1; F0 -> sysex (until F7).
//   Channel status (80-EF) stored per requester as running status; data byte (<80) opening a
//   message uses stored status length minus 1; no stored status -> length 1.
//   remain = length-1 after first byte; each further byte decrements; lock released when the
//   last byte's PACE ends. Sysex: lock held until F7 accepted; a non-realtime status byte inside
//   sysex also terminates it and starts its own message (lock kept). F8-FF inside a message
//   does not decrement remain.
//   Any system status (F0-F7) clears that requester's running status.
//  Lock timeout: 20-bit counter runs in IDLE while locked and owner valid low; at LOCK_TIMEOUT
//   lock drops, remain=0, timeout_o pulses 1 cycle; counter clears on any accept.
//  Simultaneous: ack and new valid -> valid waits until PACE ends. reset_n low mid-byte aborts at
//   once; uart_tdata_o never glitches high during or after reset.
// CONFIGURATION
//  MIDI_ACTIVE_SENSE_EN defined: internal third source; if IDLE, no lock, neither valid, and
//   SENSE_CYCLES elapsed since last ack, issue 8'hFE through ISSUE/WAIT_ACK/PACE; grant_o stays
//   00; counter restarts on every ack. A/B valid in the same cycle win over the insert.
//  Undefined: no insert, sense counter absent; behaviour otherwise identical.
// TESTING
//  A sends 90 3C 40, B valid with C0 05 throughout -> UART sees 90,3C,40,C0,05; gaps = 6880 clk.
//  A,B valid together after reset -> A first; both valid again at next boundary -> B granted.
//  A sends 90 3C 40 then 3E 40 (running status) -> second message locked 2 bytes, then release.
//  A sends F0 43 then stalls -> timeout_o pulse after LOCK_TIMEOUT clk, B then granted.
//  reset_n low during WAIT_ACK -> all outputs 0 immediately; next A byte issued normally.
//  MIDI_ACTIVE_SENSE_EN, no traffic -> uart_data_o=16'h01FE after SENSE_CYCLES, repeats.

Source files
------------

// File: rtl/midi_tx_scheduler.sv
// Shares one MIDI UART transmitter between requesters A and B, locking at message boundaries and
// pacing issues one byte-time apart. Optional active-sense insert: define MIDI_ACTIVE_SENSE_EN.
module midi_tx_scheduler #(
  parameter int BYTE_CYCLES  = 6880,
  parameter int LOCK_TIMEOUT = 1048575
`ifdef MIDI_ACTIVE_SENSE_EN
  ,
  parameter int SENSE_CYCLES = 6443100
`endif
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  a_data,
  input  logic        a_valid,
  output logic        a_ready,
  input  logic [7:0]  b_data,
  input  logic        b_valid,
  output logic        b_ready,
  output logic        uart_tdata_o,
  output logic [15:0] uart_data_o,
  input  logic        uart_txint_i,
  output logic [1:0]  grant_o,
  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    PACE     = 2'd3
  } state_t;

  localparam logic [15:0] PACE_LOAD = 16'(BYTE_CYCLES - 1);
  localparam logic [19:0] TMO_LAST  = 20'(LOCK_TIMEOUT - 1);

  // Bytes still to follow a status byte (message length minus one).
  function automatic logic [1:0] msg_remain(input logic [7:0] d);
    logic [1:0] r;
    r = 2'd0;
    case (d[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: r = 2'd2;
      4'hC, 4'hD:                   r = 2'd1;
      4'hF: begin
        case (d[3:0])
          4'h1, 4'h3: r = 2'd1;
          4'h2:       r = 2'd2;
          default:    r = 2'd0;
        endcase
      end
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // A data byte opening a message reuses the stored running status, minus the implied status byte.
  function automatic logic [1:0] start_remain(input logic [7:0] d, input logic [7:0] rs);
    logic [1:0] r;
    if (d[7]) begin
      r = msg_remain(d);
    end else if (rs[7]) begin
      r = msg_remain(rs) - 2'd1;
    end else begin
      r = 2'd0;
    end
    return r;
  endfunction

  // Running status: channel status is kept, system common/exclusive clears it, realtime leaves it.
  function automatic logic [7:0] next_rs(input logic [7:0] d, input logic [7:0] rs);
    logic [7:0] r;
    if (d[7:4] == 4'hF) begin
      r = (d[3]) ? rs : 8'h00;
    end else if (d[7]) begin
      r = d;
    end else begin
      r = rs;
    end
    return r;
  endfunction

  state_t      state_r, state_n;
  logic [1:0]  grant_r, grant_n;
  logic        last_b_r, last_b_n;
  logic [1:0]  remain_r, remain_n;
  logic        sysex_r, sysex_n;
  logic [7:0]  rs_a_r, rs_a_n, rs_b_r, rs_b_n;
  logic [15:0] pace_r, pace_n;
  logic [19:0] tmo_r, tmo_n;
  logic [15:0] data_r, data_n;
  logic        tdata_r, busy_r, timeout_r, timeout_n;

  logic [1:0]  owner_s;
  logic        lock_s, acc_a_s, acc_b_s, acc_s;
  logic [7:0]  byte_s, rs_s;

`ifdef MIDI_ACTIVE_SENSE_EN
  localparam logic [22:0] SENSE_LAST = 23'(SENSE_CYCLES - 1);
  logic [22:0] sense_r;
  logic        sense_go_s;

  assign sense_go_s = (state_r == IDLE) && (grant_r == 2'b00) && !a_valid && !b_valid &&
                      (sense_r == SENSE_LAST);

  // Idle-time counter since the last UART acknowledge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sense_r <= 23'd0;
    end else if ((state_r == WAIT_ACK) && uart_txint_i) begin
      sense_r <= 23'd0;
    end else if (sense_r != SENSE_LAST) begin
      sense_r <= sense_r + 23'd1;
    end else begin
      sense_r <= sense_r;
    end
  end
`endif

  assign lock_s  = (grant_r != 2'b00);
  assign a_ready = (state_r == IDLE) && owner_s[0];
  assign b_ready = (state_r == IDLE) && owner_s[1];
  assign acc_a_s = a_valid && a_ready;
  assign acc_b_s = b_valid && b_ready;
  assign acc_s   = acc_a_s || acc_b_s;
  assign byte_s  = acc_b_s ? b_data : a_data;
  assign rs_s    = acc_b_s ? rs_b_r : rs_a_r;

  // Owner: the lock holder, else round-robin between valid requesters.
  always_comb begin
    owner_s = 2'b00;
    if (lock_s) begin
      owner_s = grant_r;
    end else if (a_valid && b_valid) begin
      owner_s = last_b_r ? 2'b01 : 2'b10;
    end else if (a_valid) begin
      owner_s = 2'b01;
    end else if (b_valid) begin
      owner_s = 2'b10;
    end else begin
      owner_s = 2'b00;
    end
  end

  // Next-state, message tracking, pacing and lock timeout.
  always_comb begin
    state_n   = state_r;
    grant_n   = grant_r;
    last_b_n  = last_b_r;
    remain_n  = remain_r;
    sysex_n   = sysex_r;
    rs_a_n    = rs_a_r;
    rs_b_n    = rs_b_r;
    pace_n    = pace_r;
    tmo_n     = tmo_r;
    data_n    = data_r;
    timeout_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (acc_s) begin
          state_n = ISSUE;
          data_n  = {8'h01, byte_s};
          tmo_n   = 20'd0;
          if (!lock_s) begin
            grant_n  = acc_b_s ? 2'b10 : 2'b01;
            last_b_n = acc_b_s;
            sysex_n  = (byte_s == 8'hF0);
            remain_n = start_remain(byte_s, rs_s);
          end else if (byte_s >= 8'hF8) begin
            remain_n = remain_r;
          end else if (sysex_r) begin
            // Any non-realtime status ends the sysex; F7 closes it, others open their own message.
            if (byte_s == 8'hF7) begin
              sysex_n  = 1'b0;
              remain_n = 2'd0;
            end else if (byte_s[7]) begin
              sysex_n  = (byte_s == 8'hF0);
              remain_n = start_remain(byte_s, rs_s);
            end else begin
              remain_n = remain_r;
            end
          end else if (remain_r != 2'd0) begin
            remain_n = remain_r - 2'd1;
          end else begin
            remain_n = 2'd0;
          end
          if (acc_b_s) begin
            rs_b_n = next_rs(byte_s, rs_b_r);
          end else begin
            rs_a_n = next_rs(byte_s, rs_a_r);
          end
`ifdef MIDI_ACTIVE_SENSE_EN
        end else if (sense_go_s) begin
          state_n = ISSUE;
          data_n  = {8'h01, 8'hFE};
`endif
        end else if (lock_s) begin
          if (tmo_r >= TMO_LAST) begin
            grant_n   = 2'b00;
            remain_n  = 2'd0;
            sysex_n   = 1'b0;
            tmo_n     = 20'd0;
            timeout_n = 1'b1;
          end else begin
            tmo_n = tmo_r + 20'd1;
          end
        end else begin
          tmo_n = 20'd0;
        end
      end
      ISSUE: begin
        state_n = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (uart_txint_i) begin
          state_n = PACE;
          pace_n  = PACE_LOAD;
        end else begin
          state_n = WAIT_ACK;
        end
      end
      PACE: begin
        // Leaving on the 1->0 step makes ack-to-next-ready exactly BYTE_CYCLES.
        if (pace_r <= 16'd1) begin
          state_n = IDLE;
          pace_n  = 16'd0;
          if ((remain_r == 2'd0) && !sysex_r) begin
            grant_n = 2'b00;
          end else begin
            grant_n = grant_r;
          end
        end else begin
          pace_n = pace_r - 16'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n;
    end
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_r   <= 2'b00;
      last_b_r  <= 1'b1;
      remain_r  <= 2'd0;
      sysex_r   <= 1'b0;
      rs_a_r    <= 8'h00;
      rs_b_r    <= 8'h00;
      pace_r    <= 16'd0;
      tmo_r     <= 20'd0;
      data_r    <= 16'h0000;
      tdata_r   <= 1'b0;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      grant_r   <= grant_n;
      last_b_r  <= last_b_n;
      remain_r  <= remain_n;
      sysex_r   <= sysex_n;
      rs_a_r    <= rs_a_n;
      rs_b_r    <= rs_b_n;
      pace_r    <= pace_n;
      tmo_r     <= tmo_n;
      data_r    <= data_n;
      tdata_r   <= (state_r == IDLE) && (state_n == ISSUE);
      busy_r    <= (state_n != IDLE);
      timeout_r <= timeout_n;
    end
  end

  assign uart_tdata_o = tdata_r;
  assign uart_data_o  = data_r;
  assign grant_o      = grant_r;
  assign busy_o       = busy_r;
  assign timeout_o    = timeout_r;

endmodule

// File: tb/tb_midi_tx_scheduler.sv
// Directed self-checking bench for midi_tx_scheduler with shortened pacing and timeout.
module tb_midi_tx_scheduler;
  localparam int BC = 20;
  localparam int LT = 100;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  a_data = 8'h00, b_data = 8'h00;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic        a_ready, b_ready;
  logic        uart_tdata_o;
  logic [15:0] uart_data_o;
  logic        uart_txint_i = 1'b0;
  logic [1:0]  grant_o;
  logic        busy_o, timeout_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  midi_tx_scheduler #(.BYTE_CYCLES(BC), .LOCK_TIMEOUT(LT)) dut (
    .clk(clk), .reset_n(reset_n),
    .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
    .uart_tdata_o(uart_tdata_o), .uart_data_o(uart_data_o), .uart_txint_i(uart_txint_i),
    .grant_o(grant_o), .busy_o(busy_o), .timeout_o(timeout_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Requester drivers: queues feed valid/data, popped after a sampled handshake.
  logic [7:0] qa[$], qb[$];
  bit hs_a = 1'b0, hs_b = 1'b0;
  always @(negedge clk) begin
    hs_a = a_valid && a_ready;
    hs_b = b_valid && b_ready;
  end
  always @(posedge clk) begin
    #1;
    if (hs_a && qa.size() > 0) void'(qa.pop_front());
    if (hs_b && qb.size() > 0) void'(qb.pop_front());
    hs_a = 1'b0;
    hs_b = 1'b0;
    a_valid = (qa.size() != 0);
    a_data  = (qa.size() != 0) ? qa[0] : 8'h00;
    b_valid = (qb.size() != 0);
    b_data  = (qb.size() != 0) ? qb[0] : 8'h00;
  end

  // UART model: logs issues, acks two cycles later, measures ack-to-idle gap.
  bit          uart_auto = 1'b1;
  int          ack_cnt = 0, ack_cyc = 0, n_issue = 0;
  bit          meas = 1'b0;
  logic [15:0] iss_data[$];
  logic [1:0]  iss_grant[$];
  int          gaps[$];
  always @(negedge clk) begin
    uart_txint_i = 1'b0;
    if (!reset_n) begin
      ack_cnt = 0;
      meas = 1'b0;
    end else begin
      if (meas && !busy_o) begin
        gaps.push_back(cyc - ack_cyc);
        meas = 1'b0;
      end
      if (uart_tdata_o) begin
        iss_data.push_back(uart_data_o);
        iss_grant.push_back(grant_o);
        n_issue++;
        if (uart_auto) ack_cnt = 2;
      end else if (ack_cnt > 0) begin
        ack_cnt--;
        if (ack_cnt == 0) begin
          uart_txint_i = 1'b1;
          ack_cyc = cyc;
          meas = 1'b1;
        end
      end
    end
  end

  task automatic clear_logs();
    iss_data.delete();
    iss_grant.delete();
    gaps.delete();
    n_issue = 0;
  endtask

  task automatic wait_drain(output bit to);
    to = 1'b1;
    for (int n = 0; n < 4000; n++) begin
      @(negedge clk);
      if (qa.size() == 0 && qb.size() == 0 && !a_valid && !b_valid && !busy_o) begin
        to = 1'b0;
        break;
      end
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_issues(input int n, output bit to);
    to = 1'b1;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (n_issue >= n) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++; if (uart_tdata_o !== 1'b0) begin $display("FAIL reset_tdata: got %b, expected 0", uart_tdata_o); miscompares++; end
    vectors++; if (uart_data_o !== 16'h0000) begin $display("FAIL reset_data: got %h, expected 0000", uart_data_o); miscompares++; end
    vectors++; if (grant_o !== 2'b00) begin $display("FAIL reset_grant: got %b, expected 00", grant_o); miscompares++; end
    vectors++; if (busy_o !== 1'b0) begin $display("FAIL reset_busy: got %b, expected 0", busy_o); miscompares++; end
    vectors++; if (timeout_o !== 1'b0) begin $display("FAIL reset_timeout: got %b, expected 0", timeout_o); miscompares++; end
    vectors++; if ({a_ready, b_ready} !== 2'b00) begin $display("FAIL reset_ready: got %b, expected 00", {a_ready, b_ready}); miscompares++; end
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({uart_tdata_o, busy_o} !== 2'b00) begin $display("FAIL post_reset_idle: got %b, expected 00", {uart_tdata_o, busy_o}); miscompares++; end
  endtask

  task automatic test_interleave();
    logic [15:0] exp_d [5];
    logic [1:0]  exp_g [5];
    bit to;
    exp_d = '{16'h0190, 16'h013C, 16'h0140, 16'h01C0, 16'h0105};
    exp_g = '{2'b01, 2'b01, 2'b01, 2'b10, 2'b10};
    clear_logs();
    qa.push_back(8'h90); qa.push_back(8'h3C); qa.push_back(8'h40);
    qb.push_back(8'hC0); qb.push_back(8'h05);
    wait_drain(to);
    vectors++; if (to) begin $display("FAIL interleave_drain: got timeout, expected completion"); miscompares++; end
    vectors++; if (iss_data.size() != 5) begin $display("FAIL interleave_count: got %0d, expected 5", iss_data.size()); miscompares++; end
    for (int i = 0; i < 5; i++) begin
      if (i < iss_data.size()) begin
        vectors++;
        if (iss_data[i] !== exp_d[i] || iss_grant[i] !== exp_g[i]) begin
          $display("FAIL interleave_issue[%0d]: got %h/%b, expected %h/%b", i, iss_data[i], iss_grant[i], exp_d[i], exp_g[i]);
          miscompares++;
        end
      end
    end
    vectors++; if (gaps.size() != 5) begin $display("FAIL gap_count: got %0d, expected 5", gaps.size()); miscompares++; end
    for (int i = 0; i < 5; i++) begin
      if (i < gaps.size()) begin
        vectors++;
        if (gaps[i] != BC) begin $display("FAIL ack_to_ready[%0d]: got %0d, expected %0d", i, gaps[i], BC); miscompares++; end
      end
    end
    vectors++; if (grant_o !== 2'b00) begin $display("FAIL interleave_release: got %b, expected 00", grant_o); miscompares++; end
  endtask

  task automatic test_round_robin();
    logic [15:0] exp_d [3];
    logic [1:0]  exp_g [3];
    bit to;
    exp_d = '{16'h01F6, 16'h01F8, 16'h01F6};
    exp_g = '{2'b01, 2'b10, 2'b01};
    clear_logs();
    qa.push_back(8'hF6); qa.push_back(8'hF6);
    qb.push_back(8'hF8);
    wait_drain(to);
    vectors++; if (to) begin $display("FAIL rr_drain: got timeout, expected completion"); miscompares++; end
    vectors++; if (iss_data.size() != 3) begin $display("FAIL rr_count: got %0d, expected 3", iss_data.size()); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      if (i < iss_data.size()) begin
        vectors++;
        if (iss_data[i] !== exp_d[i] || iss_grant[i] !== exp_g[i]) begin
          $display("FAIL rr_issue[%0d]: got %h/%b, expected %h/%b", i, iss_data[i], iss_grant[i], exp_d[i], exp_g[i]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_running_status();
    logic [15:0] exp_d [8];
    logic [1:0]  exp_g [8];
    bit to;
    exp_d = '{16'h01F8, 16'h0190, 16'h013C, 16'h0140, 16'h01F8, 16'h013E, 16'h0140, 16'h01F8};
    exp_g = '{2'b10, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01, 2'b01, 2'b10};
    clear_logs();
    qa.push_back(8'h90); qa.push_back(8'h3C); qa.push_back(8'h40);
    qa.push_back(8'h3E); qa.push_back(8'h40);
    qb.push_back(8'hF8); qb.push_back(8'hF8); qb.push_back(8'hF8);
    wait_drain(to);
    vectors++; if (to) begin $display("FAIL rs_drain: got timeout, expected completion"); miscompares++; end
    vectors++; if (iss_data.size() != 8) begin $display("FAIL rs_count: got %0d, expected 8", iss_data.size()); miscompares++; end
    for (int i = 0; i < 8; i++) begin
      if (i < iss_data.size()) begin
        vectors++;
        if (iss_data[i] !== exp_d[i] || iss_grant[i] !== exp_g[i]) begin
          $display("FAIL rs_issue[%0d]: got %h/%b, expected %h/%b", i, iss_data[i], iss_grant[i], exp_d[i], exp_g[i]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_sysex_timeout();
    logic [15:0] exp_d [3];
    logic [1:0]  exp_g [3];
    bit to, found, seen;
    int t0, t1;
    exp_d = '{16'h01F0, 16'h0143, 16'h01F8};
    exp_g = '{2'b01, 2'b01, 2'b10};
    t0 = 0; t1 = 0; found = 1'b0; seen = 1'b0;
    clear_logs();
    qa.push_back(8'hF0); qa.push_back(8'h43);
    qb.push_back(8'hF8);
    wait_issues(2, to);
    vectors++; if (to) begin $display("FAIL sysex_issue_wait: got timeout, expected 2 issues"); miscompares++; end
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (!busy_o) begin t0 = cyc; found = 1'b1; break; end
    end
    vectors++; if (!found) begin $display("FAIL sysex_idle_wait: got timeout, expected idle"); miscompares++; end
    vectors++; if (grant_o !== 2'b01) begin $display("FAIL sysex_lock_held: got %b, expected 01", grant_o); miscompares++; end
    vectors++; if (b_ready !== 1'b0) begin $display("FAIL sysex_b_blocked: got %b, expected 0", b_ready); miscompares++; end
    for (int n = 0; n < LT + 50; n++) begin
      @(negedge clk);
      if (timeout_o) begin t1 = cyc; seen = 1'b1; break; end
    end
    vectors++; if (!seen) begin $display("FAIL timeout_seen: got no pulse, expected pulse"); miscompares++; end
    vectors++; if (t1 - t0 != LT) begin $display("FAIL timeout_delay: got %0d, expected %0d", t1 - t0, LT); miscompares++; end
    vectors++; if (grant_o !== 2'b00) begin $display("FAIL timeout_release: got %b, expected 00", grant_o); miscompares++; end
    @(negedge clk);
    vectors++; if (timeout_o !== 1'b0) begin $display("FAIL timeout_width: got %b, expected 0", timeout_o); miscompares++; end
    wait_drain(to);
    vectors++; if (to) begin $display("FAIL sysex_drain: got timeout, expected completion"); miscompares++; end
    vectors++; if (iss_data.size() != 3) begin $display("FAIL sysex_count: got %0d, expected 3", iss_data.size()); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      if (i < iss_data.size()) begin
        vectors++;
        if (iss_data[i] !== exp_d[i] || iss_grant[i] !== exp_g[i]) begin
          $display("FAIL sysex_issue[%0d]: got %h/%b, expected %h/%b", i, iss_data[i], iss_grant[i], exp_d[i], exp_g[i]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_reset_abort();
    logic [15:0] exp_d [3];
    logic [1:0]  exp_g [3];
    bit to;
    exp_d = '{16'h013C, 16'h01F8, 16'h013D};
    exp_g = '{2'b01, 2'b10, 2'b01};
    clear_logs();
    uart_auto = 1'b0;
    qa.push_back(8'h90);
    wait_issues(1, to);
    vectors++; if (to) begin $display("FAIL abort_issue_wait: got timeout, expected issue"); miscompares++; end
    repeat (2) @(negedge clk);
    vectors++; if ({busy_o, grant_o} !== 3'b101) begin $display("FAIL abort_wait_ack: got %b, expected 101", {busy_o, grant_o}); miscompares++; end
    reset_n = 1'b0;
    qa.delete();
    qb.delete();
    #1;
    vectors++; if ({uart_tdata_o, busy_o, timeout_o, grant_o} !== 5'b00000) begin $display("FAIL abort_outputs: got %b, expected 00000", {uart_tdata_o, busy_o, timeout_o, grant_o}); miscompares++; end
    vectors++; if (uart_data_o !== 16'h0000) begin $display("FAIL abort_data: got %h, expected 0000", uart_data_o); miscompares++; end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    uart_auto = 1'b1;
    @(negedge clk);
    vectors++; if (uart_tdata_o !== 1'b0) begin $display("FAIL abort_no_glitch: got %b, expected 0", uart_tdata_o); miscompares++; end
    clear_logs();
    qa.push_back(8'h3C); qa.push_back(8'h3D);
    qb.push_back(8'hF8);
    wait_drain(to);
    vectors++; if (to) begin $display("FAIL abort_drain: got timeout, expected completion"); miscompares++; end
    vectors++; if (iss_data.size() != 3) begin $display("FAIL abort_count: got %0d, expected 3", iss_data.size()); miscompares++; end
    for (int i = 0; i < 3; i++) begin
      if (i < iss_data.size()) begin
        vectors++;
        if (iss_data[i] !== exp_d[i] || iss_grant[i] !== exp_g[i]) begin
          $display("FAIL abort_issue[%0d]: got %h/%b, expected %h/%b", i, iss_data[i], iss_grant[i], exp_d[i], exp_g[i]);
          miscompares++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_interleave();
    test_round_robin();
    test_running_status();
    test_sysex_timeout();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
